// File: rtl/pl_reset_sequencer.sv
// PL reset sequencer: interconnect then staged peripheral reset release after a stable clock lock.
// Optional lock-wait timeout flag enabled by defining PL_RST_SEQ_LOCK_TIMEOUT_EN.
module pl_reset_sequencer #(
  parameter int unsigned NUM_PERIPH         = 4,
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned STAGE_GAP          = 8,
  parameter int unsigned SOFT_HOLD_CYCLES   = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                  pl_clk0,
  input  logic                  pl0_resetn,
  input  logic                  clk_wiz_locked,
  input  logic                  soft_rst_req,
  output logic                  soft_rst_ack,
  output logic                  ic_resetn,
  output logic [NUM_PERIPH-1:0] periph_resetn,
  output logic                  seq_done,
  output logic [2:0]            state_dbg,
  output logic                  lock_timeout
);

  localparam int unsigned MAX_A   = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_B   = (MAX_A > SOFT_HOLD_CYCLES) ? MAX_A : SOFT_HOLD_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_B > TIMEOUT_CYCLES) ? MAX_B : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [2:0] {
    ST_RESET          = 3'd0,
    ST_WAIT_LOCK      = 3'd1,
    ST_RELEASE_IC     = 3'd2,
    ST_RELEASE_PERIPH = 3'd3,
    ST_RUN            = 3'd4,
    ST_SOFT_HOLD      = 3'd5
  } state_t;

  logic [1:0]            lock_sync_q;
  logic                  locked_sync;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]      idx_q, idx_d, rel_idx;
  logic                  rel;
  logic                  ic_q, ic_d;
  logic [NUM_PERIPH-1:0] periph_q, periph_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  soft_q, soft_d;

  // Two-flop synchronizer for the asynchronous clock-wizard lock
  always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
    if (!pl0_resetn) lock_sync_q <= 2'b00;
    else             lock_sync_q <= {lock_sync_q[0], clk_wiz_locked};
  end
  assign locked_sync = lock_sync_q[1];

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ic_d     = ic_q;
    periph_d = periph_q;
    done_d   = done_q;
    soft_d   = soft_q;
    ack_d    = ack_q & soft_rst_req;
    cnt_inc  = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    rel      = 1'b0;
    rel_idx  = '0;

    case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        ic_d     = 1'b0;
        periph_d = '0;
        done_d   = 1'b0;
        if (!locked_sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES)) begin
          state_d = ST_RELEASE_IC;
          ic_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE_IC: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) rel = 1'b1;
        else                                cnt_d = cnt_inc;
      end
      ST_RELEASE_PERIPH: begin
        rel_idx = idx_q;
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) rel = 1'b1;
        else                                cnt_d = cnt_inc;
      end
      ST_RUN: begin
        done_d = 1'b1;
        if (soft_rst_req && !ack_q) begin
          state_d  = ST_SOFT_HOLD;
          periph_d = '0;
          done_d   = 1'b0;
          soft_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_SOFT_HOLD: begin
        periph_d = '0;
        done_d   = 1'b0;
        if (cnt_q == CNT_W'(SOFT_HOLD_CYCLES - 1)) rel = 1'b1;
        else                                       cnt_d = cnt_inc;
      end
      default: state_d = ST_RESET;
    endcase

    // Release one peripheral bit; the last one lands in RUN
    if (rel) begin
      cnt_d             = '0;
      periph_d[rel_idx] = 1'b1;
      if (rel_idx == IDX_W'(NUM_PERIPH - 1)) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
        idx_d   = '0;
        ack_d   = ack_d | soft_q;
        soft_d  = 1'b0;
      end else begin
        state_d = ST_RELEASE_PERIPH;
        idx_d   = rel_idx + IDX_W'(1);
      end
    end

    // Lock loss overrides everything, including a soft request
    if (!locked_sync && (state_q inside {ST_RELEASE_IC, ST_RELEASE_PERIPH, ST_RUN, ST_SOFT_HOLD})) begin
      state_d  = ST_WAIT_LOCK;
      ic_d     = 1'b0;
      periph_d = '0;
      done_d   = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
      soft_d   = 1'b0;
      ack_d    = ack_q & soft_rst_req;
    end
  end

  always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
    if (!pl0_resetn) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      idx_q    <= '0;
      ic_q     <= 1'b0;
      periph_q <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      soft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ic_q     <= ic_d;
      periph_q <= periph_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      soft_q   <= soft_d;
    end
  end

  assign ic_resetn     = ic_q;
  assign periph_resetn = periph_q;
  assign seq_done      = done_q;
  assign soft_rst_ack  = ack_q;
  assign state_dbg     = state_q;

`ifdef PL_RST_SEQ_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_flag_q;

  // Lock-wait watchdog; flag is sticky until pl0_resetn
  always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
    if (!pl0_resetn) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else if (state_q == ST_WAIT_LOCK) begin
      if (tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) tmo_flag_q <= 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
  assign lock_timeout = tmo_flag_q;
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Directed bench for pl_reset_sequencer: power-up, soft reset, lock loss, unstable lock, timeout.
module tb_pl_reset_sequencer;

`ifdef PL_RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic [31:0] TMO_EN = 32'd1;
`else
  localparam logic [31:0] TMO_EN = 32'd0;
`endif

  logic       pl_clk0 = 1'b0;
  logic       pl0_resetn;
  logic       clk_wiz_locked;
  logic       soft_rst_req;
  logic       soft_rst_ack;
  logic       ic_resetn;
  logic [3:0] periph_resetn;
  logic       seq_done;
  logic [2:0] state_dbg;
  logic       lock_timeout;

  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;
  int base   = 0;

  pl_reset_sequencer dut (
    .pl_clk0        (pl_clk0),
    .pl0_resetn     (pl0_resetn),
    .clk_wiz_locked (clk_wiz_locked),
    .soft_rst_req   (soft_rst_req),
    .soft_rst_ack   (soft_rst_ack),
    .ic_resetn      (ic_resetn),
    .periph_resetn  (periph_resetn),
    .seq_done       (seq_done),
    .state_dbg      (state_dbg),
    .lock_timeout   (lock_timeout)
  );

  always #5 pl_clk0 = ~pl_clk0;
  always @(posedge pl_clk0) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n - base);
    end
  endtask

  // Advance to 1 time unit after edge e (counted from reset release)
  task automatic goto(input int e);
    while (edge_n < base + e) begin
      @(posedge pl_clk0);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] st, input logic [31:0] ic,
                            input logic [31:0] per, input logic [31:0] done);
    check_eq({tag, "_state"},  32'(state_dbg),     st);
    check_eq({tag, "_ic"},     32'(ic_resetn),     ic);
    check_eq({tag, "_periph"}, 32'(periph_resetn), per);
    check_eq({tag, "_done"},   32'(seq_done),      done);
  endtask

  initial begin
    pl0_resetn     = 1'b0;
    clk_wiz_locked = 1'b0;
    soft_rst_req   = 1'b0;
    repeat (3) @(posedge pl_clk0);
    #1;
    check_outs("rst", 0, 0, 0, 0);
    check_eq("rst_ack", 32'(soft_rst_ack), 0);
    check_eq("rst_tmo", 32'(lock_timeout), 0);

    // Power-up: lock sampled at edge 10, ic at 28, periph at 36/44/52/60
    pl0_resetn = 1'b1;
    base = edge_n;
    goto(1);   check_eq("pu_wait", 32'(state_dbg), 1);
    goto(9);   clk_wiz_locked = 1'b1;
    goto(27);  check_outs("pu27", 1, 0, 4'h0, 0);
    goto(28);  check_outs("pu28", 2, 1, 4'h0, 0);
    goto(35);  check_eq("pu35_periph", 32'(periph_resetn), 4'h0);
    goto(36);  check_outs("pu36", 3, 1, 4'h1, 0);
    goto(44);  check_eq("pu44_periph", 32'(periph_resetn), 4'h3);
    goto(52);  check_eq("pu52_periph", 32'(periph_resetn), 4'h7);
    goto(59);  check_outs("pu59", 3, 1, 4'h7, 0);
    goto(60);  check_outs("pu60", 4, 1, 4'hF, 1);

    // Soft reset: enter hold at 63, bit0 back at 95, RUN with ack at 119
    goto(62);  soft_rst_req = 1'b1;
    goto(63);  check_outs("sr63", 5, 1, 4'h0, 0);
    goto(94);  check_outs("sr94", 5, 1, 4'h0, 0);
    goto(95);  check_outs("sr95", 3, 1, 4'h1, 0);
               check_eq("sr95_ack", 32'(soft_rst_ack), 0);
    goto(118); check_eq("sr118_ack", 32'(soft_rst_ack), 0);
    goto(119); check_outs("sr119", 4, 1, 4'hF, 1);
               check_eq("sr119_ack", 32'(soft_rst_ack), 1);
    goto(130); check_outs("sr130", 4, 1, 4'hF, 1);
               check_eq("sr130_ack", 32'(soft_rst_ack), 1);
    soft_rst_req = 1'b0;
    goto(131); check_eq("sr131_ack", 32'(soft_rst_ack), 0);

    // Lock loss in RUN: drop sampled at 141, visible at 143
    goto(140); clk_wiz_locked = 1'b0;
    goto(142); check_outs("ll142", 4, 1, 4'hF, 1);
    goto(143); check_outs("ll143", 1, 0, 4'h0, 0);

    // Unstable lock: high 151..160, low 161, high from 162 -> ic at 180
    goto(150); clk_wiz_locked = 1'b1;
    goto(160); clk_wiz_locked = 1'b0;
    goto(161); clk_wiz_locked = 1'b1;
    goto(175); check_outs("ul175", 1, 0, 4'h0, 0);
    goto(179); check_eq("ul179_ic", 32'(ic_resetn), 0);
    goto(180); check_outs("ul180", 2, 1, 4'h0, 0);
    goto(212); check_outs("ul212", 4, 1, 4'hF, 1);

    // Request and lock drop together: request abandoned, serviced after resequence
    goto(220); soft_rst_req = 1'b1; clk_wiz_locked = 1'b0;
    goto(223); check_outs("sim223", 1, 0, 4'h0, 0);
               check_eq("sim223_ack", 32'(soft_rst_ack), 0);
    goto(225); clk_wiz_locked = 1'b1;
    goto(244); check_outs("sim244", 2, 1, 4'h0, 0);
    goto(276); check_outs("sim276", 4, 1, 4'hF, 1);
               check_eq("sim276_ack", 32'(soft_rst_ack), 0);
    goto(277); check_outs("sim277", 5, 1, 4'h0, 0);
    goto(333); check_outs("sim333", 4, 1, 4'hF, 1);
               check_eq("sim333_ack", 32'(soft_rst_ack), 1);
    soft_rst_req = 1'b0;
    goto(334); check_eq("sim334_ack", 32'(soft_rst_ack), 0);

    // Long lock wait: WAIT_LOCK from 343, timeout flag at 343+4096
    goto(340);  clk_wiz_locked = 1'b0;
    goto(343);  check_eq("to343_state", 32'(state_dbg), 1);
    goto(4438); check_eq("to4438_tmo", 32'(lock_timeout), 0);
    goto(4439); check_eq("to4439_tmo", 32'(lock_timeout), TMO_EN);
                check_eq("to4439_state", 32'(state_dbg), 1);
    clk_wiz_locked = 1'b1;
    goto(4458); check_outs("to4458", 2, 1, 4'h0, 0);
    goto(4460); check_eq("to4460_tmo", 32'(lock_timeout), TMO_EN);

    // Asynchronous reset mid-sequence
    pl0_resetn = 1'b0;
    #2;
    check_outs("ar", 0, 0, 4'h0, 0);
    check_eq("ar_tmo", 32'(lock_timeout), 0);
    check_eq("ar_ack", 32'(soft_rst_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pl_reset_sequencer.md
Name: pl_reset_sequencer

Overview:
- Owns PL reset distribution for the extensible platform.
- After CIPS pl0_resetn releases and the clock wizard reports a stable lock, releases the interconnect reset first. It then releases the peripheral resets one at a time, a fixed gap apart.
- Re-sequences on lock loss.
- Services a software soft-reset request for peripherals with a four-phase req/ack handshake.

Parameters:
- NUM_PERIPH, 4, number of peripheral reset outputs (1..16).
- LOCK_STABLE_CYCLES, 16, consecutive synchronized-lock cycles required before sequencing.
- STAGE_GAP, 8, pl_clk0 cycles between successive reset releases (>=1).
- SOFT_HOLD_CYCLES, 32, cycles peripherals are held in reset on a soft request (>=1).
- TIMEOUT_CYCLES, 4096, lock-wait timeout (used only with the optional feature).

Ports:
- pl_clk0  in  1  PL clock from CIPS.
- pl0_resetn  in  1  Reset. Asynchronous assert, active-low.
- clk_wiz_locked  in  1  Clock wizard locked. Asynchronous to pl_clk0; 2-flop synchronized internally.
- soft_rst_req  in  1  Level request for a peripheral soft reset.
- soft_rst_ack  out  1  Soft-reset acknowledge (four-phase).
- ic_resetn  out  1  Interconnect reset, active-low, registered.
- periph_resetn  out  NUM_PERIPH  Peripheral resets, active-low, registered; bit 0 is released first.
- seq_done  out  1  High while all resets are released (RUN state).
- state_dbg  out  3  Current state encoding.
- lock_timeout  out  1  Sticky lock-wait timeout flag. Tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, pl_clk0. Reset pl0_resetn is asynchronous and active-low.
- Values while pl0_resetn=0:
  - ic_resetn=0, periph_resetn=all 0.
  - seq_done=0, soft_rst_ack=0, lock_timeout=0.
  - state=RESET, all counters 0, lock synchronizer cleared.
- State encodings: RESET=0, WAIT_LOCK=1, RELEASE_IC=2, RELEASE_PERIPH=3, RUN=4, SOFT_HOLD=5.
- RESET: moves to WAIT_LOCK on the first edge after reset release.
- WAIT_LOCK:
  - All resets asserted; stable counter increments while locked_sync=1 and clears to 0 when locked_sync=0.
  - When the counter reaches LOCK_STABLE_CYCLES, go to RELEASE_IC. ic_resetn is 1 in the same registered update.
  - Minimum latency from clk_wiz_locked rising to ic_resetn=1 is 2 synchronizer cycles + LOCK_STABLE_CYCLES.
- RELEASE_IC: waits STAGE_GAP cycles, then goes to RELEASE_PERIPH with index=0.
- RELEASE_PERIPH:
  - On entry, and then every STAGE_GAP cycles, periph_resetn[index] goes 1 and index increments.
  - After bit NUM_PERIPH-1 is released, go to RUN and set seq_done=1.
- RUN:
  - seq_done=1.
  - soft_rst_req=1 with soft_rst_ack=0: go to SOFT_HOLD.
  - soft_rst_req=0 with soft_rst_ack=1: drop soft_rst_ack.
- SOFT_HOLD:
  - All periph_resetn=0; ic_resetn stays 1; seq_done=0.
  - After SOFT_HOLD_CYCLES, go to RELEASE_PERIPH (index=0), with the same staged release.
  - On the return to RUN, soft_rst_ack=1. It holds until soft_rst_req is sampled 0.
- Handshake rules:
  - A new request is accepted only once ack is 0.
  - A request arriving outside RUN stays pending and is serviced on entry to RUN.
- Lock loss (locked_sync=0) in RELEASE_IC, RELEASE_PERIPH, RUN or SOFT_HOLD:
  - Next edge: all resets asserted, seq_done=0, go to WAIT_LOCK, counters cleared.
  - Any in-flight soft request is abandoned, with ack kept 0.
  - Lock loss takes priority over a soft request on the same cycle.
- Glitch rule: a lock drop shorter than 1 cycle that is missed by the synchronizer is not required to be detected.
- pl0_resetn assertion mid-sequence: immediately forces the reset values (asynchronous).
- Counter width: clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP, SOFT_HOLD_CYCLES, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.

Optional Feature:
- Macro: PL_RST_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in WAIT_LOCK and clears on exit.
  - When it reaches TIMEOUT_CYCLES, lock_timeout=1 (sticky until pl0_resetn). The FSM keeps waiting.
- Undefined: no timeout logic; lock_timeout is tied 0.

Test Plan:
- Power-up: release pl0_resetn, raise clk_wiz_locked at cycle 10 → ic_resetn=1 at cycle 28. periph_resetn bits release at cycles 36, 44, 52, 60. seq_done=1 from cycle 60; state_dbg=4.
- Unstable lock: locked pulses high 10 cycles, low 1, then high → counter restarts; ic_resetn rises 16+2 cycles after the final rise.
- Lock loss in RUN: drop locked → 3 cycles later all resets=0, seq_done=0, state_dbg=1. Restore lock → full resequence repeats.
- Soft reset: in RUN, raise soft_rst_req → periph_resetn=0 for 32 cycles, ic_resetn stays 1. Staged re-release follows, then soft_rst_ack=1. Drop req → ack=0 the next cycle. Holding req high after ack causes no second reset.
- Simultaneous: soft_rst_req rises on the same cycle locked drops → WAIT_LOCK, ack stays 0. The request is serviced after re-sequencing reaches RUN.
- With PL_RST_SEQ_LOCK_TIMEOUT_EN: hold locked=0 → lock_timeout=1 at cycle 4096 of WAIT_LOCK and stays 1 after lock arrives. Without the macro it stays 0.
